// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: each beat is routed to its own 2-entry FIFO per channel.
// Optional macro TDM_DEMUX2_AUTOSEL_EN replaces in_sel with an internal A/B toggle.
module tdm_demux2_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [1:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       valid_o,
  output logic [1:0] data_o
);
  logic [1:0][1:0] mem_q;
  logic            wr_q, rd_q;
  logic [1:0]      cnt_q, cnt_d;
  logic            do_pop;

  assign do_pop  = pop_i & valid_o;
  assign full_o  = (cnt_q == 2'd2);
  assign valid_o = (cnt_q != 2'd0);
  // Empty channel presents zero rather than stale storage.
  assign data_o  = valid_o ? mem_q[rd_q] : 2'b00;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

module tdm_demux2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in_data,
  input  logic       in_sel,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] a_data,
  output logic       a_valid,
  input  logic       a_ready,
  output logic [1:0] b_data,
  output logic       b_valid,
  input  logic       b_ready
);
  logic sel_eff;
  logic a_full, b_full;
  logic acc;

  // Ready looks only at occupancy, so a full FIFO never takes a beat on a pop cycle.
  assign in_ready = sel_eff ? ~b_full : ~a_full;
  assign acc      = in_valid & in_ready;

`ifdef TDM_DEMUX2_AUTOSEL_EN
  localparam logic [0:0] SEL_A = 1'b0;
  localparam logic [0:0] SEL_B = 1'b1;
  logic [0:0] state_q, state_d;

  assign sel_eff = (state_q == SEL_B);

  always_comb begin
    state_d = state_q;
    if (acc) state_d = (state_q == SEL_A) ? SEL_B : SEL_A;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEL_A;
    else     state_q <= state_d;
  end
`else
  assign sel_eff = in_sel;
`endif

  tdm_demux2_fifo u_fifo_a (
    .clk    (clk),
    .rst    (rst),
    .push_i (acc & ~sel_eff),
    .data_i (in_data),
    .pop_i  (a_ready),
    .full_o (a_full),
    .valid_o(a_valid),
    .data_o (a_data)
  );

  tdm_demux2_fifo u_fifo_b (
    .clk    (clk),
    .rst    (rst),
    .push_i (acc & sel_eff),
    .data_i (in_data),
    .pop_i  (b_ready),
    .full_o (b_full),
    .valid_o(b_valid),
    .data_o (b_data)
  );
endmodule

// File: tb/tb_tdm_demux2.sv
// Directed bench for tdm_demux2; the autosel sequence runs only when TDM_DEMUX2_AUTOSEL_EN is defined.
module tb_tdm_demux2;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_data;
  logic       in_sel, in_valid, in_ready;
  logic [1:0] a_data, b_data;
  logic       a_valid, a_ready, b_valid, b_ready;
  int checks = 0;
  int errors = 0;

  tdm_demux2 dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic sel, input logic [1:0] d);
    in_valid = 1'b1; in_sel = sel; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = 2'b00; in_sel = 1'b0; in_valid = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("rst_a_valid", {1'b0, a_valid}, 2'b00);
    chk("rst_b_valid", {1'b0, b_valid}, 2'b00);
    chk("rst_a_data", a_data, 2'b00);
    chk("rst_b_data", b_data, 2'b00);
    chk("rst_in_ready", {1'b0, in_ready}, 2'b01);

`ifndef TDM_DEMUX2_AUTOSEL_EN
    // basic routing
    push(1'b0, 2'b10);
    chk("route_a_valid", {1'b0, a_valid}, 2'b01);
    chk("route_a_data", a_data, 2'b10);
    chk("route_b_valid", {1'b0, b_valid}, 2'b00);
    a_ready = 1'b1; step(); a_ready = 1'b0;
    chk("drain_a_valid", {1'b0, a_valid}, 2'b00);
    chk("drain_a_data", a_data, 2'b00);

    // fill A, check independence of B
    push(1'b0, 2'b01);
    push(1'b0, 2'b11);
    in_sel = 1'b0; #1;
    chk("fullA_ready_sel0", {1'b0, in_ready}, 2'b00);
    in_sel = 1'b1; #1;
    chk("fullA_ready_sel1", {1'b0, in_ready}, 2'b01);
    chk("fullA_head", a_data, 2'b01);
    push(1'b1, 2'b10);
    chk("b_valid", {1'b0, b_valid}, 2'b01);
    chk("b_data", b_data, 2'b10);
    chk("a_held", a_data, 2'b01);

    // full plus pop: push must be rejected
    a_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 2'b00; #1;
    chk("fullpop_ready", {1'b0, in_ready}, 2'b00);
    step();
    in_valid = 1'b0; a_ready = 1'b0; #1;
    chk("fullpop_head", a_data, 2'b11);
    chk("fullpop_ready_after", {1'b0, in_ready}, 2'b01);
    push(1'b0, 2'b00);
    chk("after_push_head", a_data, 2'b11);
    a_ready = 1'b1; step();
    chk("pop_order2", a_data, 2'b00);
    chk("pop_order2_valid", {1'b0, a_valid}, 2'b01);
    step(); a_ready = 1'b0;
    chk("a_empty", {1'b0, a_valid}, 2'b00);
    b_ready = 1'b1; step(); b_ready = 1'b0;
    chk("b_empty", {1'b0, b_valid}, 2'b00);

    // simultaneous push/pop keeps count at 1
    push(1'b0, 2'b01);
    chk("sim_pre_head", a_data, 2'b01);
    a_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 2'b11; #1;
    chk("sim_ready", {1'b0, in_ready}, 2'b01);
    step();
    in_valid = 1'b0; a_ready = 1'b0; #1;
    chk("sim_a_valid", {1'b0, a_valid}, 2'b01);
    chk("sim_a_data", a_data, 2'b11);
    chk("sim_count1_ready", {1'b0, in_ready}, 2'b01);
    push(1'b0, 2'b10);
    chk("sim_count2_ready", {1'b0, in_ready}, 2'b00);

    // reset with both full
    push(1'b1, 2'b01);
    push(1'b1, 2'b11);
    chk("both_full_ready", {1'b0, in_ready}, 2'b00);
    rst = 1'b1; a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1; in_data = 2'b01;
    step();
    rst = 1'b0; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0; in_sel = 1'b0; #1;
    chk("mrst_a_valid", {1'b0, a_valid}, 2'b00);
    chk("mrst_b_valid", {1'b0, b_valid}, 2'b00);
    chk("mrst_a_data", a_data, 2'b00);
    chk("mrst_b_data", b_data, 2'b00);
    chk("mrst_ready_a", {1'b0, in_ready}, 2'b01);
    in_sel = 1'b1; #1;
    chk("mrst_ready_b", {1'b0, in_ready}, 2'b01);
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_no_emit_a", {1'b0, a_valid}, 2'b00);
      chk("mrst_no_emit_b", {1'b0, b_valid}, 2'b00);
    end
    a_ready = 1'b0; b_ready = 1'b0;
`else
    // in_sel held at 1 is ignored; stall cycle must not toggle
    push(1'b1, 2'b00);
    chk("auto_a0", a_data, 2'b00);
    chk("auto_b_empty", {1'b0, b_valid}, 2'b00);
    in_sel = 1'b1; step();
    chk("auto_stall_b_empty", {1'b0, b_valid}, 2'b00);
    push(1'b1, 2'b01);
    chk("auto_b0", b_data, 2'b01);
    push(1'b1, 2'b10);
    push(1'b1, 2'b11);
    chk("auto_b_head", b_data, 2'b01);
    a_ready = 1'b1; b_ready = 1'b1;
    chk("auto_a_head", a_data, 2'b00);
    step();
    chk("auto_a_second", a_data, 2'b10);
    chk("auto_b_second", b_data, 2'b11);
    step();
    a_ready = 1'b0; b_ready = 1'b0;
    chk("auto_a_done", {1'b0, a_valid}, 2'b00);
    chk("auto_b_done", {1'b0, b_valid}, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
